// File: rtl/solar_display_scanner.sv
// Display channel selector for the solar monitor: manual select or auto-scan
// with per-channel dwell, sample-and-hold, freeze and out-of-range detection.
module solar_display_scanner #(
    parameter int DATA_W       = 12,
    parameter int NUM_CH       = 5,
    parameter int SEL_W        = 3,
    parameter int DWELL_CYCLES = 1024,
    parameter int CNT_W        = 10
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    input  logic                     mode_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic                     freeze_i,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    output logic                     out_sel_err,
    output logic                     scan_done
);

    typedef enum logic [1:0] {RESET_LOAD, MANUAL, AUTO} state_t;

    localparam int                TABLE_SIZE = 2**SEL_W;
    localparam logic [SEL_W:0]    NUM_CH_W   = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(NUM_CH-1);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES-1);

    state_t              state_reg, state_next;
    logic                mode_q_reg;
    logic [CNT_W-1:0]    dwell_cnt_reg, dwell_cnt_next;
    logic [DATA_W-1:0]   out_data_reg, out_data_next;
    logic [SEL_W-1:0]    out_ch_reg, out_ch_next;
    logic                out_valid_reg, out_valid_next;
    logic                out_sel_err_reg, out_sel_err_next;
    logic                scan_done_reg, scan_done_next;

    logic                sel_ok;
    logic                mode_change;
    logic [SEL_W-1:0]    eff_ch;
    logic [SEL_W-1:0]    nxt_ch;

    // Table padded to the full select range so every index is defined.
    logic [DATA_W-1:0]   ch_table [TABLE_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < TABLE_SIZE; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_real
                assign ch_table[gi] = ch_data_i[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign ch_table[gi] = '0;
            end
        end
    endgenerate

    assign sel_ok      = ({1'b0, sel_i} < NUM_CH_W);
    assign eff_ch      = sel_ok ? sel_i : '0;
    assign nxt_ch      = (out_ch_reg == LAST_CH) ? '0 : out_ch_reg + 1'b1;
    assign mode_change = (mode_i != mode_q_reg);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg       <= RESET_LOAD;
            mode_q_reg      <= mode_i;
            dwell_cnt_reg   <= '0;
            out_data_reg    <= '0;
            out_ch_reg      <= '0;
            out_valid_reg   <= 1'b0;
            out_sel_err_reg <= 1'b0;
            scan_done_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mode_q_reg      <= mode_i;
            dwell_cnt_reg   <= dwell_cnt_next;
            out_data_reg    <= out_data_next;
            out_ch_reg      <= out_ch_next;
            out_valid_reg   <= out_valid_next;
            out_sel_err_reg <= out_sel_err_next;
            scan_done_reg   <= scan_done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        dwell_cnt_next   = dwell_cnt_reg;
        out_data_next    = out_data_reg;
        out_ch_next      = out_ch_reg;
        out_valid_next   = 1'b0;
        out_sel_err_next = 1'b0;
        scan_done_next   = 1'b0;

        case (state_reg)
            RESET_LOAD: begin
                out_valid_next = 1'b1;
                dwell_cnt_next = '0;
                if (mode_i) begin
                    state_next    = AUTO;
                    out_ch_next   = '0;
                    out_data_next = ch_table[0];
                end else begin
                    state_next       = MANUAL;
                    out_ch_next      = eff_ch;
                    out_data_next    = ch_table[eff_ch];
                    out_sel_err_next = ~sel_ok;
                end
            end
            MANUAL, AUTO: begin
                if (!mode_i) begin
                    state_next       = MANUAL;
                    dwell_cnt_next   = '0;
                    out_ch_next      = eff_ch;
                    out_data_next    = ch_table[eff_ch];
                    out_sel_err_next = ~sel_ok;
                    out_valid_next   = (eff_ch != out_ch_reg);
                end else if (mode_change) begin
                    // Entering auto: re-sample the channel already on display.
                    state_next     = AUTO;
                    dwell_cnt_next = '0;
                    out_data_next  = ch_table[out_ch_reg];
                    out_valid_next = 1'b1;
                end else if (!freeze_i) begin
                    if (dwell_cnt_reg == DWELL_LAST) begin
                        dwell_cnt_next = '0;
                        out_ch_next    = nxt_ch;
                        out_data_next  = ch_table[nxt_ch];
                        out_valid_next = 1'b1;
                        scan_done_next = (nxt_ch == '0);
                    end else begin
                        dwell_cnt_next = dwell_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = RESET_LOAD;
            end
        endcase
    end

    assign out_data    = out_data_reg;
    assign out_ch      = out_ch_reg;
    assign out_valid   = out_valid_reg;
    assign out_sel_err = out_sel_err_reg;
    assign scan_done   = scan_done_reg;

endmodule

// File: tb/tb_solar_display_scanner.sv
// Directed-vector bench for solar_display_scanner (5 channels, dwell of 4 cycles).
module tb_solar_display_scanner;

    localparam int DATA_W = 12;
    localparam int NUM_CH = 5;
    localparam int SEL_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic                     freeze;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_sel_err;
    logic                     scan_done;

    int n_compared = 0;
    int n_mismatch = 0;

    solar_display_scanner #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .SEL_W       (SEL_W),
        .DWELL_CYCLES(4),
        .CNT_W       (2)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .ch_data_i  (ch_data),
        .mode_i     (mode),
        .sel_i      (sel),
        .freeze_i   (freeze),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_sel_err(out_sel_err),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("[%0t] rst=%b mode=%b sel=%0d frz=%b -> ch=%0d data=%h valid=%b err=%b done=%b",
                 $time, rst, mode, sel, freeze, out_ch, out_data, out_valid, out_sel_err, scan_done);
    endtask

    function automatic logic [31:0] base_val(input int c);
        return 32'((c + 1) * 32'h111);
    endfunction

    initial begin
        rst     = 1'b1;
        mode    = 1'b0;
        sel     = 3'd1;
        freeze  = 1'b0;
        ch_data = {12'h555, 12'h444, 12'h333, 12'h222, 12'h111};

        // Reset held for two edges, manual select of channel 1
        repeat (2) begin
            tick();
            check("rst_data", out_data, 0);
            check("rst_ch", out_ch, 0);
            check("rst_valid", out_valid, 0);
        end
        rst = 1'b0;
        tick();
        check("rl_data", out_data, 32'h222);
        check("rl_ch", out_ch, 1);
        check("rl_valid", out_valid, 1);
        check("rl_err", out_sel_err, 0);
        tick();
        check("man_hold_valid", out_valid, 0);
        check("man_hold_data", out_data, 32'h222);

        // Data change alone: follows with one cycle latency, no pulse
        ch_data[1*DATA_W +: DATA_W] = 12'h2AB;
        tick();
        check("man_dchg_data", out_data, 32'h2AB);
        check("man_dchg_valid", out_valid, 0);
        ch_data[1*DATA_W +: DATA_W] = 12'h222;

        // Out-of-range select falls back to channel 0
        sel = 3'd6;
        tick();
        check("oor_data", out_data, 32'h111);
        check("oor_ch", out_ch, 0);
        check("oor_err", out_sel_err, 1);
        check("oor_valid", out_valid, 1);
        sel = 3'd4;
        tick();
        check("sel4_data", out_data, 32'h555);
        check("sel4_ch", out_ch, 4);
        check("sel4_err", out_sel_err, 0);
        check("sel4_valid", out_valid, 1);

        // Manual ch2 -> auto: re-sample ch2, then advance after 4 cycles
        sel = 3'd2;
        tick();
        check("sel2_ch", out_ch, 2);
        check("sel2_data", out_data, 32'h333);
        mode = 1'b1;
        tick();
        check("m2a_ch", out_ch, 2);
        check("m2a_data", out_data, 32'h333);
        check("m2a_valid", out_valid, 1);
        check("m2a_err", out_sel_err, 0);
        repeat (3) begin
            tick();
            check("m2a_dwell_ch", out_ch, 2);
            check("m2a_dwell_valid", out_valid, 0);
        end
        tick();
        check("m2a_adv_ch", out_ch, 3);
        check("m2a_adv_data", out_data, 32'h444);
        check("m2a_adv_valid", out_valid, 1);

        // Auto -> manual with sel=2 while showing ch3
        mode = 1'b0;
        tick();
        check("a2m_ch", out_ch, 2);
        check("a2m_data", out_data, 32'h333);
        check("a2m_valid", out_valid, 1);

        // Auto scan from reset; sel out of range is ignored in auto
        rst  = 1'b1;
        mode = 1'b1;
        sel  = 3'd7;
        tick();
        check("ars_data", out_data, 0);
        check("ars_ch", out_ch, 0);
        check("ars_err", out_sel_err, 0);
        rst = 1'b0;
        tick();
        check("arl_ch", out_ch, 0);
        check("arl_data", out_data, 32'h111);
        check("arl_valid", out_valid, 1);
        check("arl_done", scan_done, 0);
        for (int k = 1; k <= 20; k++) begin
            int c;
            tick();
            c = (k / 4) % NUM_CH;
            check("scan_ch", out_ch, c);
            check("scan_data", out_data, base_val(c));
            check("scan_valid", out_valid, (k % 4 == 0) ? 1 : 0);
            check("scan_done", scan_done, (k % 4 == 0 && c == 0) ? 1 : 0);
            check("scan_err", out_sel_err, 0);
            // Mid-dwell data change on ch1 must not reach out_data
            if (k == 5) ch_data[1*DATA_W +: DATA_W] = 12'hABC;
        end
        ch_data[1*DATA_W +: DATA_W] = 12'h222;

        // Freeze on ch3 with dwell count 2
        repeat (14) tick();
        check("frz_pre_ch", out_ch, 3);
        freeze = 1'b1;
        repeat (10) begin
            tick();
            check("frz_ch", out_ch, 3);
            check("frz_data", out_data, 32'h444);
            check("frz_valid", out_valid, 0);
            check("frz_done", scan_done, 0);
        end
        freeze = 1'b0;
        tick();
        check("frz_rel1_ch", out_ch, 3);
        check("frz_rel1_valid", out_valid, 0);
        tick();
        check("frz_rel2_ch", out_ch, 4);
        check("frz_rel2_data", out_data, 32'h555);
        check("frz_rel2_valid", out_valid, 1);

        // Reset mid-scan while frozen on ch3
        repeat (16) tick();
        check("rms_pre_ch", out_ch, 3);
        freeze = 1'b1;
        rst    = 1'b1;
        tick();
        check("rms_data", out_data, 0);
        check("rms_ch", out_ch, 0);
        check("rms_valid", out_valid, 0);
        check("rms_done", scan_done, 0);
        check("rms_err", out_sel_err, 0);
        rst = 1'b0;
        tick();
        check("rms_rl_ch", out_ch, 0);
        check("rms_rl_data", out_data, 32'h111);
        check("rms_rl_valid", out_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/solar_display_scanner.md
Name: solar_display_scanner

Overview:
- Parametrised successor to the fixed 5-way registered display selector in the solar monitor top level.
- Selects one of NUM_CH display channels (voltage, current, power, temperature, efficiency, plus future channels) and drives a registered output onto the analog_io display pins.
- Adds an auto-scan mode: the block cycles through the channels with a programmable dwell time and sample-and-hold on each channel.
- Adds out-of-range select detection and a freeze control.

Parameters:
- DATA_W, 12, width of each display channel and of out_data.
- NUM_CH, 5, number of channels; legal range 2..2**SEL_W.
- SEL_W, 3, width of sel_i and out_ch.
- DWELL_CYCLES, 1024, clock cycles each channel is held in auto mode; must be >= 1.
- CNT_W, 10, dwell counter width; must satisfy 2**CNT_W >= DWELL_CYCLES.

Ports:
- wb_clk_i  input  1  single clock, rising-edge.
- wb_rst_i  input  1  synchronous reset, active-high.
- ch_data_i  input  NUM_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- mode_i  input  1  0 = manual, 1 = auto-scan.
- sel_i  input  SEL_W  manual channel select.
- freeze_i  input  1  auto mode only: hold the current channel, counter and out_data.
- out_data  output  DATA_W  registered selected or held value.
- out_ch  output  SEL_W  channel index currently shown.
- out_valid  output  1  one-cycle pulse on every load of out_data from a new channel.
- out_sel_err  output  1  manual mode: registered flag, high while sel_i >= NUM_CH.
- scan_done  output  1  one-cycle pulse when auto scan wraps from NUM_CH-1 to 0.

Behaviour:
- Reset: wb_rst_i is sampled only at a rising edge of wb_clk_i and overrides all other inputs. It sets out_data=0, out_ch=0, out_valid=0, out_sel_err=0, scan_done=0, dwell_cnt=0, state=RESET_LOAD, and mode_q = mode_i.
- State RESET_LOAD is one cycle, entered only from reset.
  - Loads channel 0 (auto) or the effective manual channel (manual).
  - Pulses out_valid.
  - Transitions to MANUAL or AUTO according to mode_i.
- Effective manual channel: eff = sel_i if sel_i < NUM_CH, else 0.
- State MANUAL:
  - Every cycle: out_data <= ch_data_i[eff], out_ch <= eff, out_sel_err <= (sel_i >= NUM_CH).
  - Latency from sel_i or ch_data_i to out_data is 1 cycle.
  - out_valid pulses only when eff differs from the current out_ch; a data change alone does not pulse it.
  - freeze_i is ignored.
  - scan_done = 0.
- State AUTO:
  - out_sel_err = 0; sel_i is ignored.
  - out_data is sample-and-hold: loaded once on channel entry and not updated while dwelling.
  - Advance: when freeze_i=0, dwell_cnt increments each cycle.
  - When dwell_cnt == DWELL_CYCLES-1 and freeze_i=0, the next edge does all of the following:
    - nxt = (out_ch == NUM_CH-1) ? 0 : out_ch+1.
    - out_ch <= nxt, out_data <= ch_data_i[nxt].
    - dwell_cnt <= 0, out_valid <= 1.
    - scan_done <= 1 only when nxt == 0.
  - Each channel is therefore shown for exactly DWELL_CYCLES cycles. With DWELL_CYCLES=1 the channel advances every cycle.
  - freeze_i=1: dwell_cnt, out_ch and out_data hold; no pulses. Release resumes from the held count, not from 0.
- Mode transitions (mode_i is registered into mode_q; a change is detected when mode_i != mode_q):
  - MANUAL -> AUTO: on the first AUTO edge, dwell_cnt <= 0, out_data <= ch_data_i[out_ch] (re-sample the same channel), out_valid <= 1. The scan continues from the current out_ch.
  - AUTO -> MANUAL: manual rules apply from the first MANUAL edge. out_valid pulses only if eff != out_ch. dwell_cnt <= 0.
  - A mode change and the dwell terminal count in the same cycle: the mode change wins and the channel does not advance.
- Reset mid-scan: on the next edge, all outputs take their reset values regardless of freeze_i or mode_i; RESET_LOAD follows.
- Arithmetic: the channel index wraps explicitly and never indexes beyond NUM_CH-1. dwell_cnt never exceeds DWELL_CYCLES-1.
- Outputs are all registered; no combinational path from any input to any output.

Test Plan:
- Reset, then manual select: NUM_CH=5; hold wb_rst_i 2 cycles with ch_data = {5,4,3,2,1} * 0x111 and sel_i=1 -> during reset out_data=0 and out_ch=0. First cycle after reset: out_data=0x222, out_ch=1, out_valid=1. Thereafter out_valid=0.
- Manual out-of-range: sel_i=6 -> next cycle out_data=ch0=0x111, out_ch=0, out_sel_err=1, out_valid=1. Then sel_i=4 -> out_data=0x555, out_sel_err=0, out_valid=1.
- Auto scan: DWELL_CYCLES=4, mode_i=1 from reset -> out_ch sequence 0,1,2,3,4,0 with 4 cycles each. out_valid pulses every 4 cycles. scan_done pulses once on the 4->0 wrap. Changing ch_data mid-dwell does not alter out_data.
- Freeze: auto, DWELL_CYCLES=4, freeze_i=1 for 10 cycles at dwell_cnt=2 on ch 3 -> out_ch stays 3, no pulses. After release, the advance to ch 4 occurs exactly 2 cycles later (dwell_cnt 2 -> 3, then the next edge advances).
- Mode switch: manual on ch 2, switch to auto -> same-edge re-sample of ch 2 with out_valid=1, then advance to ch 3 after 4 cycles. Switch back to manual with sel_i=2 while on ch 3 -> out_ch=2 and out_valid=1 next cycle.
- Reset mid-scan: auto on ch 3 with freeze_i=1, assert wb_rst_i for 1 cycle -> next edge all outputs 0. Then RESET_LOAD gives out_ch=0, out_data=0x111, out_valid=1.
